// File: rtl/stopwatch_bcd.sv
// Multi-digit BCD stopwatch/timer: prescaled up/down count with wrap or saturate,
// synchronous preload, lap capture and per-digit 7-segment decode.
module stopwatch_bcd #(
    parameter int NDIGITS   = 2,
    parameter int MAX_COUNT = 59,
    parameter int TICK_DIV  = 1,
    parameter int WRAP      = 1
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 freeze,
    input  logic                 down,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] load_bcd,
    input  logic                 lap_cap,
    input  logic                 lap_show,
    output logic [4*NDIGITS-1:0] count_bcd,
    output logic [8*NDIGITS-1:0] seg,
    output logic                 terminal,
    output logic                 load_err
);
    localparam int W  = 4 * NDIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] res;
        int           r;
        res = '0;
        r   = value;
        for (int i = 0; i < NDIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h67;
            default: return 8'h00;
        endcase
    endfunction

    // Valid BCD values order the same way as their decimal values, so the
    // terminal compare can be done directly on the packed nibbles.
    localparam logic [W-1:0]  MAX_BCD    = to_bcd(MAX_COUNT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  lap_q, lap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          terminal_q, terminal_d;
    logic          load_err_q, load_err_d;

    logic          load_ok;
    logic          tick;
    logic          at_limit;
    logic          step_term;
    logic [W-1:0]  step_val;
    logic [W-1:0]  disp;

    assign load_ok = bcd_valid(load_bcd) && (load_bcd <= MAX_BCD);

    // Next value if a step happens this cycle, and whether it earns a terminal pulse.
    always_comb begin
        at_limit = down ? (count_q == '0) : (count_q == MAX_BCD);
        if (!at_limit) begin
            step_val = down ? bcd_dec(count_q) : bcd_inc(count_q);
        end else if (WRAP != 0) begin
            step_val = down ? MAX_BCD : '0;
        end else begin
            step_val = count_q;
        end
        if (at_limit) begin
            step_term = (WRAP != 0);
        end else begin
            step_term = down ? (step_val == '0) : (step_val == MAX_BCD);
        end
    end

    always_comb begin
        count_d    = count_q;
        presc_d    = presc_q;
        lap_d      = lap_cap ? count_q : lap_q;
        terminal_d = 1'b0;
        load_err_d = 1'b0;
        tick       = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_bcd;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (!freeze && run) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (tick) begin
            count_d    = step_val;
            terminal_d = step_term;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            count_q    <= '0;
            lap_q      <= '0;
            presc_q    <= '0;
            terminal_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            lap_q      <= lap_d;
            presc_q    <= presc_d;
            terminal_q <= terminal_d;
            load_err_q <= load_err_d;
        end
    end

    // Display path is purely combinational so lap_show switches immediately.
    always_comb begin
        disp = lap_show ? lap_q : count_q;
        seg  = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            seg[8*i +: 8] = seg7(disp[4*i +: 4]);
        end
        seg[7] = lap_show;
    end

    assign count_bcd = count_q;
    assign terminal  = terminal_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: three instances (div 2 wrap, div 1 wrap, div 1 saturate)
// share stimulus; a decimal reference model feeds a per-cycle scoreboard.
module tb_stopwatch_bcd;
    localparam int MAXV = 59;

    logic       clk_2 = 1'b0;
    logic       reset, run, freeze, down, load, lap_cap, lap_show;
    logic [7:0] load_bcd;

    logic [7:0]  cnt  [3];
    logic [15:0] sg   [3];
    logic        term [3];
    logic        lerr [3];

    typedef struct packed {
        logic [2:0][7:0]  cnt;
        logic [2:0][15:0] seg;
        logic [2:0]       term;
        logic [2:0]       lerr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   m_cnt [3];
    int   m_pre [3];
    int   m_lap [3];
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk_2 = ~clk_2;

    stopwatch_bcd #(.NDIGITS(2), .MAX_COUNT(59), .TICK_DIV(2), .WRAP(1)) dut0 (
        .clk_2(clk_2), .reset(reset), .run(run), .freeze(freeze), .down(down),
        .load(load), .load_bcd(load_bcd), .lap_cap(lap_cap), .lap_show(lap_show),
        .count_bcd(cnt[0]), .seg(sg[0]), .terminal(term[0]), .load_err(lerr[0]));
    stopwatch_bcd #(.NDIGITS(2), .MAX_COUNT(59), .TICK_DIV(1), .WRAP(1)) dut1 (
        .clk_2(clk_2), .reset(reset), .run(run), .freeze(freeze), .down(down),
        .load(load), .load_bcd(load_bcd), .lap_cap(lap_cap), .lap_show(lap_show),
        .count_bcd(cnt[1]), .seg(sg[1]), .terminal(term[1]), .load_err(lerr[1]));
    stopwatch_bcd #(.NDIGITS(2), .MAX_COUNT(59), .TICK_DIV(1), .WRAP(0)) dut2 (
        .clk_2(clk_2), .reset(reset), .run(run), .freeze(freeze), .down(down),
        .load(load), .load_bcd(load_bcd), .lap_cap(lap_cap), .lap_show(lap_show),
        .count_bcd(cnt[2]), .seg(sg[2]), .terminal(term[2]), .load_err(lerr[2]));

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic bit wrap_of(input int k);
        return k != 2;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h67;
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model with the currently driven inputs, push the expectation, clock.
    task automatic apply_cycle();
        exp_t x;
        int   hi, lo, dsp;
        x  = '0;
        hi = int'(load_bcd[7:4]);
        lo = int'(load_bcd[3:0]);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
            end else begin
                if (lap_cap) m_lap[k] = m_cnt[k];
                if (load) begin
                    if (hi <= 9 && lo <= 9 && hi * 10 + lo <= MAXV) begin
                        m_cnt[k] = hi * 10 + lo;
                        m_pre[k] = 0;
                    end else begin
                        x.lerr[k] = 1'b1;
                    end
                end else if (run && !freeze) begin
                    if (m_pre[k] < div_of(k) - 1) begin
                        m_pre[k]++;
                    end else begin
                        m_pre[k] = 0;
                        if (!down) begin
                            if (m_cnt[k] < MAXV) begin
                                m_cnt[k]++;
                                x.term[k] = (m_cnt[k] == MAXV);
                            end else if (wrap_of(k)) begin
                                m_cnt[k] = 0;
                                x.term[k] = 1'b1;
                            end
                        end else begin
                            if (m_cnt[k] > 0) begin
                                m_cnt[k]--;
                                x.term[k] = (m_cnt[k] == 0);
                            end else if (wrap_of(k)) begin
                                m_cnt[k] = MAXV;
                                x.term[k] = 1'b1;
                            end
                        end
                    end
                end
            end
            dsp = lap_show ? m_lap[k] : m_cnt[k];
            x.cnt[k] = 8'((m_cnt[k] / 10) * 16 + m_cnt[k] % 10);
            x.seg[k] = {seg_of(dsp / 10), seg_of(dsp % 10) | {lap_show, 7'b0}};
        end
        sb.push_back(x);
        @(posedge clk_2);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; freeze = 1'b0; down = 1'b0; load = 1'b0;
        lap_cap = 1'b0; lap_show = 1'b0; load_bcd = 8'h00;
        for (int c = 0; c < 2; c++) begin
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL reset count dut%0d: got %h want %h", k, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL reset seg dut%0d: got %h want %h", k, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL reset terminal dut%0d: got %b want %b", k, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL reset load_err dut%0d: got %b want %b", k, lerr[k], e.lerr[k]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_chk += 2;
            if (cnt[k] !== 8'h00) begin n_err++; $display("FAIL reset_const count dut%0d: got %h want 00", k, cnt[k]); end
            if (sg[k] !== 16'h3F3F) begin n_err++; $display("FAIL reset_const seg dut%0d: got %h want 3f3f", k, sg[k]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_carry();
        run = 1'b1; down = 1'b0;
        for (int c = 0; c < 20; c++) begin
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL carry count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL carry seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL carry terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL carry load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        n_chk += 3;
        if (cnt[0] !== 8'h10) begin n_err++; $display("FAIL carry_const count dut0: got %h want 10", cnt[0]); end
        if (sg[0] !== 16'h063F) begin n_err++; $display("FAIL carry_const seg dut0: got %h want 063f", sg[0]); end
        if (cnt[1] !== 8'h20) begin n_err++; $display("FAIL carry_const count dut1: got %h want 20", cnt[1]); end
    endtask

    task automatic test_wrap_up();
        int pulses;
        pulses = 0;
        run = 1'b1; down = 1'b0; load_bcd = 8'h58;
        for (int c = 0; c < 5; c++) begin
            load = (c == 0);
            apply_cycle();
            e = sb.pop_front();
            if (c > 0 && term[2] === 1'b1) pulses++;
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL wrap_up count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL wrap_up seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL wrap_up terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL wrap_up load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        load = 1'b0;
        n_chk += 3;
        if (pulses != 1) begin n_err++; $display("FAIL sat_pulses dut2: got %0d want 1", pulses); end
        if (cnt[2] !== 8'h59) begin n_err++; $display("FAIL sat_hold count dut2: got %h want 59", cnt[2]); end
        if (cnt[1] !== 8'h02) begin n_err++; $display("FAIL wrap_const count dut1: got %h want 02", cnt[1]); end
    endtask

    task automatic test_down();
        run = 1'b1; down = 1'b1; load_bcd = 8'h10;
        for (int c = 0; c < 15; c++) begin
            load = (c == 0);
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL down count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL down seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL down terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL down load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        load = 1'b0;
        n_chk += 2;
        if (cnt[2] !== 8'h00) begin n_err++; $display("FAIL down_const count dut2: got %h want 00", cnt[2]); end
        if (cnt[1] !== 8'h56) begin n_err++; $display("FAIL down_const count dut1: got %h want 56", cnt[1]); end
    endtask

    task automatic test_load_err();
        int pulses;
        pulses = 0;
        run = 1'b0; down = 1'b0;
        for (int c = 0; c < 4; c++) begin
            load     = (c == 0 || c == 2);
            load_bcd = (c < 2) ? 8'h6A : 8'h60;
            apply_cycle();
            e = sb.pop_front();
            if (lerr[1] === 1'b1) pulses++;
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL load_err count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL load_err seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL load_err terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL load_err flag dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        load = 1'b0;
        n_chk += 2;
        if (pulses != 2) begin n_err++; $display("FAIL load_err_pulses dut1: got %0d want 2", pulses); end
        if (cnt[1] !== 8'h56) begin n_err++; $display("FAIL load_err_hold count dut1: got %h want 56", cnt[1]); end
    endtask

    task automatic test_lap();
        run = 1'b1; down = 1'b0; load_bcd = 8'h23;
        for (int c = 0; c < 7; c++) begin
            load     = (c == 0);
            lap_cap  = (c == 1);
            lap_show = (c >= 5);
            if (c == 5) begin
                #1;
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (sg[k] !== 16'h5BCF) begin n_err++; $display("FAIL lap_show seg dut%0d: got %h want 5bcf", k, sg[k]); end
                end
                n_chk++;
                if (cnt[1] !== 8'h27) begin n_err++; $display("FAIL lap_show count dut1: got %h want 27", cnt[1]); end
            end
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL lap count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL lap seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL lap terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL lap load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        load = 1'b0; lap_cap = 1'b0; lap_show = 1'b0;
    endtask

    task automatic test_freeze();
        run = 1'b1; down = 1'b0;
        for (int c = 0; c < 11; c++) begin
            freeze  = (c >= 1 && c <= 5);
            lap_cap = (c == 3);
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL freeze count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL freeze seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL freeze terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL freeze load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
        freeze = 1'b0; lap_cap = 1'b0;
    endtask

    task automatic test_reset_load();
        reset = 1'b1; load = 1'b1; load_bcd = 8'h6A; lap_cap = 1'b1; run = 1'b1;
        apply_cycle();
        e = sb.pop_front();
        reset = 1'b0; load = 1'b0; lap_cap = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk += 4;
            if (cnt[k] !== 8'h00) begin n_err++; $display("FAIL reset_load count dut%0d: got %h want 00", k, cnt[k]); end
            if (lerr[k] !== 1'b0) begin n_err++; $display("FAIL reset_load load_err dut%0d: got %b want 0", k, lerr[k]); end
            if (term[k] !== e.term[k]) begin n_err++; $display("FAIL reset_load terminal dut%0d: got %b want %b", k, term[k], e.term[k]); end
            if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL reset_load seg dut%0d: got %h want %h", k, sg[k], e.seg[k]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_bcd = 8'($urandom_range(0, 255));
            freeze   = ($urandom_range(0, 7) == 0);
            run      = ($urandom_range(0, 3) != 0);
            lap_cap  = ($urandom_range(0, 9) == 0);
            lap_show = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) down = !down;
            apply_cycle();
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (cnt[k] !== e.cnt[k]) begin n_err++; $display("FAIL b2b count dut%0d cyc%0d: got %h want %h", k, c, cnt[k], e.cnt[k]); end
                if (sg[k] !== e.seg[k]) begin n_err++; $display("FAIL b2b seg dut%0d cyc%0d: got %h want %h", k, c, sg[k], e.seg[k]); end
                if (term[k] !== e.term[k]) begin n_err++; $display("FAIL b2b terminal dut%0d cyc%0d: got %b want %b", k, c, term[k], e.term[k]); end
                if (lerr[k] !== e.lerr[k]) begin n_err++; $display("FAIL b2b load_err dut%0d cyc%0d: got %b want %b", k, c, lerr[k], e.lerr[k]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
        end
        test_reset();
        test_carry();
        test_wrap_up();
        test_down();
        test_load_err();
        test_lap();
        test_freeze();
        test_reset_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
